// File: rtl/sram64kb_ctrl_if.sv
// Request/response bus between the system bus slave and the SRAM64KB request sequencer.
interface sram64kb_ctrl_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [15:0] REQ_ADDR;
  logic [7:0]  REQ_WDATA;
  logic        RSP_VALID;
  logic [7:0]  RSP_RDATA;

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
    input  REQ_READY, RSP_VALID, RSP_RDATA
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
    output REQ_READY, RSP_VALID, RSP_RDATA
  );
endinterface

// File: rtl/sram64kb_ctrl.sv
// Single-byte request sequencer for the 64-bank SRAM64KB array (SETUP/STROBE/read-wait).
// Optional bank repair (spare-bank remap at acceptance) is enabled by defining MEMCTRL_REPAIR_EN.
module sram64kb_ctrl #(
  parameter int RD_WAIT = 1
) (
  input  logic        CLK,
  input  logic        RSTN,
  sram64kb_ctrl_if.slave bus,
  output logic [9:0]  MEM_ADDR,
  output logic        MEM_CE,
  output logic        MEM_WEB,
  output logic [63:0] MEM_OEB,
  output logic [63:0] MEM_CSB,
  output logic [7:0]  MEM_IDATA,
  output logic [5:0]  MEM_ODATA_SELECT,
  input  logic [7:0]  MEM_ODATA
`ifdef MEMCTRL_REPAIR_EN
  ,
  input  logic        REPAIR_VALID,
  input  logic [5:0]  REPAIR_BANK,
  input  logic [5:0]  SPARE_BANK
`endif
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RDWAIT} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(RD_WAIT - 1);

  state_t      state;
  logic        is_rd;
  logic [3:0]  wait_cnt;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [5:0]  req_bank;
  logic [5:0]  eff_bank;

  assign req_bank = bus.REQ_ADDR[15:10];

`ifdef MEMCTRL_REPAIR_EN
  assign eff_bank = (REPAIR_VALID && (req_bank == REPAIR_BANK)) ? SPARE_BANK : req_bank;
`else
  assign eff_bank = req_bank;
`endif

  assign bus.REQ_READY = (state == IDLE);
  assign bus.RSP_VALID = rsp_valid;
  assign bus.RSP_RDATA = rsp_rdata;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state            <= IDLE;
      is_rd            <= 1'b0;
      wait_cnt         <= '0;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= '0;
      MEM_ADDR         <= '0;
      MEM_CE           <= 1'b0;
      MEM_WEB          <= 1'b1;
      MEM_OEB          <= '1;
      MEM_CSB          <= '1;
      MEM_IDATA        <= '0;
      MEM_ODATA_SELECT <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.REQ_VALID) begin
            MEM_ADDR         <= bus.REQ_ADDR[9:0];
            MEM_ODATA_SELECT <= eff_bank;
            MEM_CSB          <= ~(64'h1 << eff_bank);
            MEM_WEB          <= ~bus.REQ_WE;
            MEM_IDATA        <= bus.REQ_WDATA;
            is_rd            <= ~bus.REQ_WE;
            state            <= SETUP;
          end
        end
        SETUP: begin
          MEM_CE <= 1'b1;
          // CSB already holds the one-hot bank, so it doubles as the OEB pattern
          if (is_rd) MEM_OEB <= MEM_CSB;
          state <= STROBE;
        end
        STROBE: begin
          MEM_CE <= 1'b0;
          if (is_rd) begin
            wait_cnt <= WAIT_LOAD;
            state    <= RDWAIT;
          end else begin
            MEM_CSB <= '1;
            MEM_WEB <= 1'b1;
            state   <= IDLE;
          end
        end
        RDWAIT: begin
          if (wait_cnt == 4'd0) begin
            rsp_rdata <= MEM_ODATA;
            rsp_valid <= 1'b1;
            MEM_OEB   <= '1;
            MEM_CSB   <= '1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram64kb_ctrl.sv
// Directed bench for sram64kb_ctrl: RD_WAIT=1 instance backed by a byte-array SRAM model,
// plus an RD_WAIT=3 instance with a fixed read pattern for the reset-during-RDWAIT case.
module tb_sram64kb_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  sram64kb_ctrl_if bus ();
  sram64kb_ctrl_if bus3 ();

  logic [9:0]  m_addr, m3_addr;
  logic        m_ce, m3_ce, m_web, m3_web;
  logic [63:0] m_oeb, m_csb, m3_oeb, m3_csb;
  logic [7:0]  m_idata, m3_idata, m_odata, m3_odata;
  logic [5:0]  m_sel, m3_sel;

`ifdef MEMCTRL_REPAIR_EN
  logic       rep_valid;
  logic [5:0] rep_bank, spare_bank;
`endif

  sram64kb_ctrl #(.RD_WAIT(1)) u_dut (
    .CLK(clk), .RSTN(rstn), .bus(bus),
    .MEM_ADDR(m_addr), .MEM_CE(m_ce), .MEM_WEB(m_web), .MEM_OEB(m_oeb), .MEM_CSB(m_csb),
    .MEM_IDATA(m_idata), .MEM_ODATA_SELECT(m_sel), .MEM_ODATA(m_odata)
`ifdef MEMCTRL_REPAIR_EN
    , .REPAIR_VALID(rep_valid), .REPAIR_BANK(rep_bank), .SPARE_BANK(spare_bank)
`endif
  );

  sram64kb_ctrl #(.RD_WAIT(3)) u_dut3 (
    .CLK(clk), .RSTN(rstn), .bus(bus3),
    .MEM_ADDR(m3_addr), .MEM_CE(m3_ce), .MEM_WEB(m3_web), .MEM_OEB(m3_oeb), .MEM_CSB(m3_csb),
    .MEM_IDATA(m3_idata), .MEM_ODATA_SELECT(m3_sel), .MEM_ODATA(m3_odata)
`ifdef MEMCTRL_REPAIR_EN
    , .REPAIR_VALID(1'b0), .REPAIR_BANK(6'd0), .SPARE_BANK(6'd0)
`endif
  );

  // SRAM model: write into the bank whose CSB is low on the CE cycle, read through the output mux
  logic [7:0] mem [0:65535];
  always @(posedge clk)
    if (m_ce && !m_web)
      for (int i = 0; i < 64; i++)
        if (!m_csb[i]) mem[{6'(i), m_addr}] <= m_idata;
  assign m_odata  = (m_oeb[m_sel] == 1'b0) ? mem[{m_sel, m_addr}] : 8'h00;
  assign m3_odata = (m3_oeb[m3_sel] == 1'b0) ? 8'h3C : 8'h00;

  int n_chk = 0, n_err = 0;
  int cyc = 0, ce_cnt = 0, acc_cnt = 0, rsp3_cnt = 0, viol = 0;
  int acc_cyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_ce) ce_cnt <= ce_cnt + 1;
    if (rstn && bus.REQ_VALID && bus.REQ_READY) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc.push_back(cyc);
    end
    if (bus3.RSP_VALID) rsp3_cnt <= rsp3_cnt + 1;
  end

  always @(negedge clk)
    if ($countones(~m_csb) > 1 || $countones(~m_oeb) > 1 || (!m_web && m_oeb != '1) ||
        $countones(~m3_csb) > 1 || $countones(~m3_oeb) > 1 || (!m3_web && m3_oeb != '1))
      viol <= viol + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE    = we;
    bus.REQ_ADDR  = a;
    bus.REQ_WDATA = d;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    drive(1'b1, a, d);
    tick();
    bus.REQ_VALID = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_read(input logic [15:0] a, output logic [7:0] d);
    int n;
    n = 0;
    drive(1'b0, a, 8'h00);
    tick();
    bus.REQ_VALID = 1'b0;
    while (!bus.RSP_VALID && n < 20) begin
      tick();
      n++;
    end
    chk("rd_rsp_seen", bus.RSP_VALID, 1'b1);
    d = bus.RSP_RDATA;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    int gap;
    rstn = 1'b0;
    bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'b1; bus.REQ_ADDR = 16'h1234; bus.REQ_WDATA = 8'hFF;
    bus3.REQ_VALID = 1'b1; bus3.REQ_WE = 1'b0; bus3.REQ_ADDR = 16'h0800; bus3.REQ_WDATA = 8'h00;
`ifdef MEMCTRL_REPAIR_EN
    rep_valid = 1'b0; rep_bank = 6'd0; spare_bank = 6'd0;
`endif

    // Test 1: reset values, requests ignored while in reset
    repeat (3) tick();
    chk("rst_ce", m_ce, 1'b0);
    chk("rst_web", m_web, 1'b1);
    chk("rst_oeb", m_oeb, '1);
    chk("rst_csb", m_csb, '1);
    chk("rst_addr", m_addr, 10'h0);
    chk("rst_idata", m_idata, 8'h0);
    chk("rst_sel", m_sel, 6'h0);
    chk("rst_rsp_valid", bus.RSP_VALID, 1'b0);
    chk("rst_rdata", bus.RSP_RDATA, 8'h0);
    chk("rst_ready", bus.REQ_READY, 1'b1);
    chk("rst_no_ce", ce_cnt, 0);
    chk("rst3_csb", m3_csb, '1);
    @(negedge clk);
    bus.REQ_VALID = 1'b0;
    bus3.REQ_VALID = 1'b0;
    rstn = 1'b1;

    // Test 2: write 0x1234 <- 0xA5
    drive(1'b1, 16'h1234, 8'hA5);
    tick();
    bus.REQ_VALID = 1'b0;
    chk("wr_setup_addr", m_addr, 10'h234);
    chk("wr_setup_sel", m_sel, 6'd4);
    chk("wr_setup_csb", m_csb, ~(64'h1 << 4));
    chk("wr_setup_web", m_web, 1'b0);
    chk("wr_setup_idata", m_idata, 8'hA5);
    chk("wr_setup_ce", m_ce, 1'b0);
    chk("wr_setup_ready", bus.REQ_READY, 1'b0);
    tick();
    chk("wr_strobe_ce", m_ce, 1'b1);
    chk("wr_strobe_oeb", m_oeb, '1);
    chk("wr_strobe_ready", bus.REQ_READY, 1'b0);
    tick();
    chk("wr_done_ce", m_ce, 1'b0);
    chk("wr_done_ready", bus.REQ_READY, 1'b1);
    chk("wr_done_csb", m_csb, '1);
    chk("wr_done_web", m_web, 1'b1);
    chk("wr_no_rsp", bus.RSP_VALID, 1'b0);

    // Test 3: read 0x1234, RD_WAIT=1
    drive(1'b0, 16'h1234, 8'h00);
    tick();
    bus.REQ_VALID = 1'b0;
    chk("rd_setup_oeb", m_oeb, '1);
    chk("rd_setup_web", m_web, 1'b1);
    tick();
    chk("rd_strobe_ce", m_ce, 1'b1);
    chk("rd_strobe_oeb", m_oeb, ~(64'h1 << 4));
    tick();
    chk("rd_wait_ce", m_ce, 1'b0);
    chk("rd_wait_oeb", m_oeb, ~(64'h1 << 4));
    chk("rd_wait_rsp", bus.RSP_VALID, 1'b0);
    chk("rd_wait_ready", bus.REQ_READY, 1'b0);
    tick();
    chk("rd_rsp_valid", bus.RSP_VALID, 1'b1);
    chk("rd_rdata", bus.RSP_RDATA, 8'hA5);
    chk("rd_end_oeb", m_oeb, '1);
    chk("rd_end_csb", m_csb, '1);
    chk("rd_end_ready", bus.REQ_READY, 1'b1);
    tick();
    chk("rd_rsp_clear", bus.RSP_VALID, 1'b0);
    chk("rd_rdata_hold", bus.RSP_RDATA, 8'hA5);

    // Test 4: back-to-back writes with REQ_VALID held high
    drive(1'b1, 16'h0000, 8'h11);
    tick();
    bus.REQ_ADDR = 16'hFFFF;
    bus.REQ_WDATA = 8'h22;
    tick();
    tick();
    tick();
    bus.REQ_VALID = 1'b0;
    chk("b2b_addr", m_addr, 10'h3FF);
    chk("b2b_csb", m_csb, ~(64'h1 << 63));
    chk("b2b_sel", m_sel, 6'd63);
    chk("b2b_idata", m_idata, 8'h22);
    gap = acc_cyc[acc_cyc.size() - 1] - acc_cyc[acc_cyc.size() - 2];
    chk("b2b_gap", gap, 3);
    tick();
    tick();
    do_read(16'h0000, rd);
    chk("b2b_rd0", rd, 8'h11);
    do_read(16'hFFFF, rd);
    chk("b2b_rd1", rd, 8'h22);

    // Test 5: reset during RDWAIT on the RD_WAIT=3 instance
    @(negedge clk);
    bus3.REQ_VALID = 1'b1; bus3.REQ_WE = 1'b0; bus3.REQ_ADDR = 16'h0800;
    tick();
    bus3.REQ_VALID = 1'b0;
    tick();
    tick();
    tick();
    chk("r3_wait_oeb", m3_oeb, ~(64'h1 << 2));
    chk("r3_wait_rsp", bus3.RSP_VALID, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("r3_rst_ce", m3_ce, 1'b0);
    chk("r3_rst_csb", m3_csb, '1);
    chk("r3_rst_oeb", m3_oeb, '1);
    chk("r3_rst_web", m3_web, 1'b1);
    chk("r3_rst_addr", m3_addr, 10'h0);
    chk("r3_rst_sel", m3_sel, 6'h0);
    chk("r3_rst_ready", bus3.REQ_READY, 1'b1);
    chk("mid_rst_rdata", bus.RSP_RDATA, 8'h0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) tick();
    chk("r3_no_rsp", rsp3_cnt, 0);
    @(negedge clk);
    bus3.REQ_VALID = 1'b1;
    tick();
    bus3.REQ_VALID = 1'b0;
    repeat (4) tick();
    chk("r3_rsp_early", bus3.RSP_VALID, 1'b0);
    tick();
    chk("r3_rsp_valid", bus3.RSP_VALID, 1'b1);
    chk("r3_rdata", bus3.RSP_RDATA, 8'h3C);
    tick();
    chk("r3_rsp_once", rsp3_cnt, 1);

`ifdef MEMCTRL_REPAIR_EN
    // Test 6: bank 4 remapped to spare bank 63
    rep_valid = 1'b1; rep_bank = 6'd4; spare_bank = 6'd63;
    do_write(16'h1234, 8'h5A);
    chk("rep_ce_pulse", m_ce, 1'b0);
    drive(1'b0, 16'h1234, 8'h00);
    tick();
    bus.REQ_VALID = 1'b0;
    rep_valid = 1'b0;
    chk("rep_csb", m_csb, ~(64'h1 << 63));
    chk("rep_csb4", m_csb[4], 1'b1);
    chk("rep_sel", m_sel, 6'd63);
    chk("rep_addr", m_addr, 10'h234);
    tick();
    chk("rep_oeb", m_oeb, ~(64'h1 << 63));
    tick();
    tick();
    chk("rep_rsp", bus.RSP_VALID, 1'b1);
    chk("rep_rdata", bus.RSP_RDATA, 8'h5A);
    do_read(16'h1234, rd);
    chk("rep_off_rdata", rd, 8'hA5);
`endif

    tick();
    chk("ce_per_req", ce_cnt, acc_cnt);
    chk("onehot_viol", viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
